// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// funct3 encodings follow the RV32 load/store tables; load and store spaces overlap.
package lsu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // SZ_NONE marks an unsupported funct3: one access, no lanes, zero load data.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } lsu_size_e;

  typedef struct packed {
    lsu_size_e size;
    logic      sext;
  } lsu_dec_t;

  function automatic lsu_dec_t lsu_decode(input logic we, input logic [2:0] f3);
    lsu_dec_t d;
    d.size = SZ_NONE;
    d.sext = 1'b0;
    if (we) begin
      case (f3)
        F3_SB:   d.size = SZ_BYTE;
        F3_SH:   d.size = SZ_HALF;
        F3_SW:   d.size = SZ_WORD;
        default: d.size = SZ_NONE;
      endcase
    end else begin
      case (f3)
        F3_LB:   begin d.size = SZ_BYTE; d.sext = 1'b1; end
        F3_LH:   begin d.size = SZ_HALF; d.sext = 1'b1; end
        F3_LW:   d.size = SZ_WORD;
        F3_LBU:  d.size = SZ_BYTE;
        F3_LHU:  d.size = SZ_HALF;
        default: d.size = SZ_NONE;
      endcase
    end
    return d;
  endfunction

  function automatic logic lsu_split(input lsu_size_e size, input logic [1:0] off);
    logic s;
    case (size)
      SZ_HALF: s = (off == 2'd3);
      SZ_WORD: s = (off != 2'd0);
      default: s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a single-cycle pulse with no backpressure.
interface lsu_if #(
  parameter int SIZE = 256
) ();
  localparam int LOGSIZE = $clog2(SIZE);

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_funct3;
  logic [LOGSIZE+1:0] req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               mem_en;
  logic               mem_we;
  logic [LOGSIZE-1:0] mem_addr;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  // master: the load/store unit itself; slave: pipeline plus memory around it
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/byte-enable shift across a 64-bit
// window and load realignment with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic        sext_i,
  input  logic [1:0]  off_i,
  input  logic        split_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] rdata_i,
  output logic [63:0] wdata64_o,
  output logic [7:0]  be8_o,
  output logic [31:0] ldata_o
);

  logic [31:0] size_mask;
  logic [3:0]  be4;
  logic [5:0]  sh;
  logic [63:0] data64;
  logic [63:0] shifted;

  assign sh = {off_i, 3'b000};

  always_comb begin
    size_mask = '0;
    be4       = '0;
    case (size_i)
      SZ_BYTE: begin size_mask = 32'h0000_00FF; be4 = 4'b0001; end
      SZ_HALF: begin size_mask = 32'h0000_FFFF; be4 = 4'b0011; end
      SZ_WORD: begin size_mask = 32'hFFFF_FFFF; be4 = 4'b1111; end
      default: begin size_mask = '0;            be4 = 4'b0000; end
    endcase
  end

  assign wdata64_o = {32'b0, wdata_i & size_mask} << sh;
  assign be8_o     = {4'b0000, be4} << off_i;

  // A split load holds the first word in lo_i and the second arrives on rdata_i.
  assign data64  = split_i ? {rdata_i, lo_i} : {32'b0, rdata_i};
  assign shifted = data64 >> sh;

  always_comb begin
    ldata_o = '0;
    case (size_i)
      SZ_BYTE: ldata_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ldata_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
      SZ_WORD: ldata_o = shifted[31:0];
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time, misaligned accesses split into
// two word accesses against a 1-cycle-latency byte-enabled memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SIZE = 256
) (
  input  logic       clk,
  input  logic       rst,
  lsu_if.master      bus,
  output lsu_state_e dbg_state_o
);

  localparam int LOGSIZE = $clog2(SIZE);

  lsu_state_e         state_q;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [LOGSIZE+1:0] addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [WIDTH-1:0]   lo_q;

  lsu_dec_t           dec;
  logic               split;
  logic [LOGSIZE-1:0] word0;
  logic [LOGSIZE-1:0] word1;
  logic [63:0]        wdata64;
  logic [7:0]         be8;
  logic [WIDTH-1:0]   ldata;

  assign dec   = lsu_decode(we_q, f3_q);
  assign split = lsu_split(dec.size, addr_q[1:0]);
  assign word0 = addr_q[LOGSIZE+1:2];
  assign word1 = (word0 == LOGSIZE'(SIZE - 1)) ? '0 : word0 + LOGSIZE'(1);

  lsu_lane_align u_align (
    .size_i    (dec.size),
    .sext_i    (dec.sext),
    .off_i     (addr_q[1:0]),
    .split_i   (split),
    .wdata_i   (wdata_q),
    .lo_i      (lo_q),
    .rdata_i   (bus.mem_rdata),
    .wdata64_o (wdata64),
    .be8_o     (be8),
    .ldata_o   (ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            state_q <= ST_ACC0;
          end
        end
        ST_ACC0: state_q <= split ? ST_ACC1 : ST_DONE;
        ST_ACC1: begin
          // mem_rdata here is the word read during ACC0
          if (!we_q) lo_q <= bus.mem_rdata;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      ST_ACC0: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = word0;
        bus.mem_be    = be8[3:0];
        bus.mem_wdata = we_q ? wdata64[31:0] : '0;
      end
      ST_ACC1: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = word1;
        bus.mem_be    = be8[7:4];
        bus.mem_wdata = we_q ? wdata64[63:32] : '0;
      end
      ST_DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = we_q ? '0 : ldata;
      end
      default: begin
        bus.resp_valid = 1'b0;
      end
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-level reference model predicts every
// output cycle; a memory model answers the DUT's word accesses.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int SIZE    = 256;
  localparam int LOGSIZE = $clog2(SIZE);
  localparam int W       = 72 + LOGSIZE;

  typedef struct packed {
    logic               rdy;
    logic               en;
    logic               we;
    logic [LOGSIZE-1:0] addr;
    logic [3:0]         be;
    logic [31:0]        wd;
    logic               rv;
    logic [31:0]        rd;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  lsu_state_e dbg_state;

  lsu_if #(.SIZE(SIZE)) bus ();

  load_store_unit #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  logic [31:0]  mem [SIZE];
  logic [31:0]  rd_next = '0;
  logic [7:0]   ref_b [4*SIZE];
  logic [W-1:0] exp_q [$];
  int           errors = 0;
  int           checks = 0;
  logic [31:0]  last_rdata = '0;

  // Memory: accesses take effect mid-cycle, read data appears after the next edge.
  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int l = 0; l < 4; l++)
          if (bus.mem_be[l]) mem[bus.mem_addr][8*l +: 8] = bus.mem_wdata[8*l +: 8];
      end else begin
        rd_next = mem[bus.mem_addr];
      end
    end
  end

  always @(posedge clk) bus.mem_rdata <= rd_next;

  always @(negedge clk) begin
    rec_t act;
    rec_t exp;
    act = '{bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_be,
            bus.mem_wdata, bus.resp_valid, bus.resp_rdata};
    if (exp_q.size() > 0) exp = rec_t'(exp_q.pop_front());
    else exp = '{1'b1, 1'b0, 1'b0, '0, 4'b0, 32'b0, 1'b0, 32'b0};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs t=%0t actual rdy=%b en=%b we=%b addr=%0d be=%b wd=%h rv=%b rd=%h required rdy=%b en=%b we=%b addr=%0d be=%b wd=%h rv=%b rd=%h",
               $time, act.rdy, act.en, act.we, act.addr, act.be, act.wd, act.rv, act.rd,
               exp.rdy, exp.en, exp.we, exp.addr, exp.be, exp.wd, exp.rv, exp.rd);
    end
    if (bus.resp_valid) last_rdata = bus.resp_rdata;
  end

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx] = val;
    for (int l = 0; l < 4; l++) ref_b[4*idx + l] = val[8*l +: 8];
  endtask

  // Byte-level model: which bytes the request touches, where they land, what a load returns.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [LOGSIZE+1:0] addr,
                           input logic [31:0] wd, input int max_acc, output int nrec);
    int          n;
    bit          sgn;
    bit          ok;
    int          off;
    int          nacc;
    logic [31:0] val;
    int          wa  [2];
    logic [3:0]  be  [2];
    logic [31:0] wdw [2];
    rec_t        r;
    n = 0; sgn = 0; ok = 1;
    if (we) begin
      case (f3)
        3'd0: n = 1;
        3'd1: n = 2;
        3'd2: n = 4;
        default: ok = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin n = 1; sgn = 1; end
        3'd1: begin n = 2; sgn = 1; end
        3'd2: n = 4;
        3'd4: n = 1;
        3'd5: n = 2;
        default: ok = 0;
      endcase
    end
    off   = int'(addr[1:0]);
    wa[0] = int'(addr) / 4;
    wa[1] = (wa[0] + 1) % SIZE;
    be[0] = '0; be[1] = '0; wdw[0] = '0; wdw[1] = '0;
    nacc  = 1;
    for (int i = 0; i < n; i++) begin
      int p;
      p = off + i;
      if (p >= 4) nacc = 2;
      be[p/4][p%4] = 1'b1;
      if (we) wdw[p/4][8*(p%4) +: 8] = wd[8*i +: 8];
    end
    val = '0;
    if (ok && !we) begin
      for (int i = 0; i < n; i++) val[8*i +: 8] = ref_b[(int'(addr) + i) % (4*SIZE)];
      if (sgn && val[8*n-1]) for (int j = n; j < 4; j++) val[8*j +: 8] = 8'hFF;
    end
    nrec = 0;
    for (int a = 0; a < nacc && a < max_acc; a++) begin
      r = '{1'b0, 1'b1, we, LOGSIZE'(wa[a]), be[a], wdw[a], 1'b0, 32'b0};
      exp_q.push_back(W'(r));
      nrec++;
      if (we) for (int l = 0; l < 4; l++) if (be[a][l]) ref_b[4*wa[a] + l] = wdw[a][8*l +: 8];
    end
    if (max_acc >= nacc) begin
      r = '{1'b0, 1'b0, 1'b0, '0, 4'b0, 32'b0, 1'b1, (we ? 32'b0 : val)};
      exp_q.push_back(W'(r));
      nrec++;
    end
  endtask

  // Called on a falling edge; returns on the falling edge of the first idle cycle after the response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [LOGSIZE+1:0] addr,
                        input logic [31:0] wd);
    int nrec;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    model_req(we, f3, addr, wd, 2, nrec);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (nrec) @(negedge clk);
  endtask

  initial begin
    int nrec;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < SIZE; i++) set_word(i, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state actual=%0d required=%0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);

    do_req(1'b1, F3_SW, 10'h00C, 32'hDEADBEEF);
    do_req(1'b1, F3_SB, 10'h00D, 32'h00003210);
    pin("sb_merge", mem[3], 32'hDEAD10EF);

    set_word(3, 32'h98763210);
    set_word(4, 32'h3210F0F0);
    do_req(1'b0, F3_LW, 10'h00E, 32'h0);
    pin("split_lw", last_rdata, 32'hF0F09876);

    set_word(4, 32'h800000F0);
    set_word(5, 32'h000000FF);
    do_req(1'b0, F3_LH, 10'h013, 32'h0);
    pin("split_lh", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, F3_LHU, 10'h013, 32'h0);
    pin("split_lhu", last_rdata, 32'h0000FF80);
    do_req(1'b0, F3_LB, 10'h010, 32'h0);
    pin("lb_neg", last_rdata, 32'hFFFFFFF0);

    do_req(1'b1, F3_SW, 10'(4*SIZE - 2), 32'h11223344);
    pin("wrap_hi_word", mem[SIZE-1], 32'h33440000);
    pin("wrap_lo_word", mem[0], 32'h00001122);
    do_req(1'b0, F3_LW, 10'(4*SIZE - 2), 32'h0);
    pin("wrap_lw", last_rdata, 32'h11223344);

    do_req(1'b1, F3_SH, 10'h021, 32'hCAFEBEEF);
    pin("sh_off1", mem[8], 32'h00BEEF00);
    do_req(1'b0, F3_LH, 10'h022, 32'h0);
    pin("lh_off2", last_rdata, 32'h000000BE);
    do_req(1'b0, F3_LBU, 10'h022, 32'h0);
    do_req(1'b0, F3_LB, 10'h021, 32'h0);
    pin("lb_off1", last_rdata, 32'hFFFFFFEF);

    do_req(1'b0, 3'b011, 10'h00C, 32'h0);
    pin("unsup_load", last_rdata, 32'h0);
    do_req(1'b1, 3'b111, 10'h00C, 32'hFFFFFFFF);
    pin("unsup_store", mem[3], 32'h98763210);

    // Reset lands during the first access of a split store.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SW;
    bus.req_addr   = 10'h041;
    bus.req_wdata  = 32'hAABBCCDD;
    @(posedge clk);
    model_req(1'b1, F3_SW, 10'h041, 32'hAABBCCDD, 1, nrec);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid_state actual=%0d required=%0d", dbg_state, ST_IDLE);
    end
    pin("rst_no_acc1", mem[17], 32'h0);
    do_req(1'b0, F3_LW, 10'h040, 32'h0);
    pin("rst_then_lw", last_rdata, 32'hBBCCDD00);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
